// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// multicycle_control_fsm: Moore main control unit for the multi-cycle MIPS datapath. Rev 1.0.
// Optional macro ILLEGAL_OP_TRAP_EN parks the FSM in TRAP on an unsupported opcode until reset.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ExtSel,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUOp,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB,
    MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       illegal_flag;
  logic       set_illegal;
  logic [2:0] imm_alu_op;
  logic       imm_zero_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      illegal_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_flag <= 1'b1;
    end
  end

  assign State     = state;
  assign IllegalOp = illegal_flag;

  // Immediate-class ALU operation, shared by EXEC_I and I_WB (IR is stable in both).
  always_comb begin
    imm_alu_op   = 3'b100;
    imm_zero_ext = 1'b0;
    case (Opcode)
      OP_ORI:  begin imm_alu_op = 3'b101; imm_zero_ext = 1'b1; end
      OP_ANDI: begin imm_alu_op = 3'b110; imm_zero_ext = 1'b1; end
      OP_LUI:  imm_alu_op = 3'b010;
      default: ;
    endcase
  end

  always_comb begin
    state_next  = FETCH;
    set_illegal = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ExtSel      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b100;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        state_next = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_R:                             state_next = EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_next = EXEC_I;
          OP_LW, OP_SW:                     state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_next = BRANCH;
          OP_J:                             state_next = JUMP;
          default: begin
            set_illegal = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
            state_next  = TRAP;
`else
            state_next  = FETCH;
`endif
          end
        endcase
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 3'b111;
        state_next = R_WB;
      end
      R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = imm_alu_op;
        ExtSel     = imm_zero_ext;
        state_next = I_WB;
      end
      I_WB: begin
        RegWrite = 1'b1;
        ALUOp    = imm_alu_op;
        ExtSel   = imm_zero_ext;
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? FETCH : MEM_WRITE;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b011;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (Opcode == OP_BNE);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: state_next = TRAP;
`endif
      default: state_next = FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// tb_multicycle_control_fsm: instruction-level trace model compared against the control FSM every cycle.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, memto_reg, reg_dst, reg_write, ext_sel, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ExtSel, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
    .State(State)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ExtSel, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

  outs_t exp_o;
  string tag;
  bit    have_exp = 1'b0;
  bit    ill = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  // Per-cycle comparison against the trace entry posted by the driver.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (have_exp) begin
        n_cmp++;
        if (act !== exp_o) begin
          n_bad++;
          $display("FAIL cycle %0d %s: got %05h expected %05h", cyc, tag, act, exp_o);
        end
      end
    end
  end

  task automatic pin(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL pin %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic outs_t base();
    outs_t o;
    o            = '0;
    o.alu_op     = 3'b100;
    o.illegal_op = ill;
    return o;
  endfunction

  function automatic outs_t fetch_o(input logic mr);
    outs_t o;
    o           = base();
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'b01;
    o.ir_write  = mr;
    o.pc_write  = mr;
    return o;
  endfunction

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return 3'b101;
      OP_ANDI: return 3'b110;
      OP_LUI:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic step(input logic rn, input logic mr, input logic [5:0] op, input outs_t o,
                      input string t);
    @(negedge clk);
    reset    = rn;
    MemReady = mr;
    Opcode   = op;
    exp_o    = o;
    tag      = t;
    have_exp = 1'b1;
  endtask

  task automatic reset_pulse(input int n);
    ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, OP_BAD, fetch_o(1'b1), "reset");
      #3;
      pin("reset_memread", {7'd0, MemRead}, 8'd1);
      pin("reset_aluop", {5'd0, ALUOp}, 8'h4);
      pin("reset_illegal", {7'd0, IllegalOp}, 8'd0);
    end
  endtask

  // Expands one instruction into its expected per-cycle output trace.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    outs_t o;
    for (int i = 0; i < fw; i++) step(1'b1, 1'b0, op, fetch_o(1'b0), "fetch_wait");
    step(1'b1, 1'b1, op, fetch_o(1'b1), "fetch");
    o = base(); o.alu_src_b = 2'b11;
    step(1'b1, 1'b1, op, o, "decode");
    case (op)
      OP_R: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_op = 3'b111;
        step(1'b1, 1'b1, op, o, "exec_r");
        #3; pin("r_aluop", {5'd0, ALUOp}, 8'h7);
        o = base(); o.reg_dst = 1'b1; o.reg_write = 1'b1;
        step(1'b1, 1'b0, op, o, "r_wb");
        #3; pin("r_regdst", {7'd0, RegDst}, 8'd1);
      end
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        o.alu_op = imm_op(op); o.ext_sel = (op == OP_ORI) || (op == OP_ANDI);
        step(1'b1, 1'b1, op, o, "exec_i");
        #3;
        if (op == OP_ORI) begin
          pin("ori_aluop", {5'd0, ALUOp}, 8'h5);
          pin("ori_extsel", {7'd0, ExtSel}, 8'd1);
        end
        if (op == OP_LUI) pin("lui_aluop", {5'd0, ALUOp}, 8'h2);
        o.alu_src_a = 1'b0; o.alu_src_b = 2'b00; o.reg_write = 1'b1;
        step(1'b1, 1'b0, op, o, "i_wb");
      end
      OP_LW, OP_SW: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        step(1'b1, 1'b1, op, o, "mem_addr");
        o = base(); o.iord = 1'b1;
        if (op == OP_LW) o.mem_read = 1'b1; else o.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) step(1'b1, 1'b0, op, o, "mem_wait");
        if (!abort) begin
          step(1'b1, 1'b1, op, o, "mem_ready");
          if (op == OP_LW) begin
            o = base(); o.memto_reg = 1'b1; o.reg_write = 1'b1;
            step(1'b1, 1'b1, op, o, "mem_wb");
            #3; pin("lw_memtoreg", {7'd0, MemtoReg}, 8'd1);
          end
        end
      end
      OP_BEQ, OP_BNE: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_op = 3'b011; o.pc_write_cond = 1'b1;
        o.pc_source = 2'b01; o.branch_ne = (op == OP_BNE);
        step(1'b1, 1'b0, op, o, "branch");
        #3;
        if (op == OP_BNE) pin("bne_branchne", {7'd0, BranchNE}, 8'd1);
        else              pin("beq_branchne", {7'd0, BranchNE}, 8'd0);
      end
      OP_J: begin
        o = base(); o.pc_write = 1'b1; o.pc_source = 2'b10;
        step(1'b1, 1'b1, op, o, "jump");
      end
      default: begin
        ill = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 10; i++) step(1'b1, i[0], op, base(), "trap");
        #3; pin("trap_illegal", {7'd0, IllegalOp}, 8'd1);
        reset_pulse(1);
`endif
      end
    endcase
  endtask

  initial begin
    reset    = 1'b0;
    MemReady = 1'b1;
    Opcode   = OP_R;
    reset_pulse(2);
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_ORI, 0, 0, 1'b0);
    run_instr(OP_ANDI, 1, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(OP_LUI, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_SW, 2, 2, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_BAD, 0, 0, 1'b0);
    run_instr(OP_R, 0, 0, 1'b0);
    #3; pin("illegal_sticky", {7'd0, IllegalOp}, 8'd1);
    // Reset in the middle of a load's memory wait, released with memory ready.
    run_instr(OP_LW, 0, 3, 1'b1);
    reset_pulse(2);
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 0, 1'b0);
    @(negedge clk);
    have_exp = 1'b0;
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS datapath.
- Directly upstream of the ALU control decoder: generates the 3-bit ALUOp plus all datapath enables and mux selects.
- Moore FSM decoding opcode of the latched instruction; memory-access states stall on a ready handshake from the unified instruction/data memory.

Parameters:
- STATE_W, 4, width of state register and debug State port.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous active-low reset; forces state to FETCH
- Opcode  input  6  instruction[31:26] from instruction register
- MemReady  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if branch condition holds
- BranchNE  output  1  branch condition is !Zero (BNE) instead of Zero (BEQ)
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ExtSel  output  1  immediate extension: 0 = sign, 1 = zero
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = ext imm, 11 = ext imm << 2
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  output  3  to ALU control: 111 R-type, 100 add, 101 or, 110 and, 011 subtract/compare, 010 LUI
- IllegalOp  output  1  sticky unsupported-opcode flag
- State  output  STATE_W  current state (debug)

Behaviour:
- Opcodes: R 000000, ADDI 001000, ORI 001101, ANDI 001100, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
- Outputs are decoded combinationally from the state register only. Opcode affects next state and ALUOp in EXEC_I. MemReady gates the outputs noted below.
- Any output not listed for a state is 0. ALUOp default is 100.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00. IRWrite=PCWrite=MemReady. Stay in FETCH until MemReady, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target into ALUOut). Next state:
  - R → EXEC_R
  - ADDI/ORI/ANDI/LUI → EXEC_I
  - LW/SW → MEM_ADDR
  - BEQ/BNE → BRANCH
  - J → JUMP
  - other → FETCH, and set IllegalOp.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10.
  - ALUOp: 100 for ADDI, 101 for ORI, 110 for ANDI, 010 for LUI.
  - ExtSel=1 for ORI/ANDI, 0 otherwise.
  - Next state I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1. ExtSel and ALUOp held as in EXEC_I. Next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Next state MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1. Hold until MemReady, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until MemReady, then go to FETCH. MemWrite stays asserted for the whole wait.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCWriteCond=1, PCSource=01, BranchNE=(Opcode==BNE). Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Opcode is sampled only in DECODE, EXEC_I, MEM_ADDR, BRANCH and I_WB. The IR is stable in all of these.
- Reset, asserted anywhere including mid-wait:
  - State=FETCH and IllegalOp=0 immediately.
  - Output values during reset are the FETCH values: MemRead=1, ALUSrcB=01, ALUOp=100, IRWrite=PCWrite=MemReady.
  - The PC and IR registers are held by their own reset, so MemReady-gated writes during reset are harmless.
- Unused state encodings → FETCH on the next clock.
- No state is visited without forward progress, except the two MemReady waits, which have no timeout.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE enters a TRAP state instead of FETCH. IllegalOp=1.
  - In TRAP all enables are 0. TRAP is left only by reset.
- Not defined:
  - No TRAP state exists. An unsupported opcode returns to FETCH, so the instruction acts as a NOP.
  - IllegalOp is still set (sticky until reset).

Test Plan:
- Reset low mid MEM_READ wait, then release with MemReady=1 → State=FETCH, IllegalOp=0. IRWrite=PCWrite=1 in the first cycle; DECODE follows.
- ADD (Opcode 000000), MemReady=1 → FETCH, DECODE, EXEC_R (ALUOp=111), R_WB (RegWrite=1, RegDst=1); 4 cycles total.
- ORI (001101) → EXEC_I with ALUOp=101, ExtSel=1. I_WB has RegWrite=1, RegDst=0. LUI gives ALUOp=010.
- LW with MemReady low for 3 cycles in MEM_READ → MemRead and IorD held 3 extra cycles. Then MEM_WB (MemtoReg=1, RegWrite=1); 8 cycles total.
- BNE (000101) → BRANCH with ALUOp=011, PCWriteCond=1, BranchNE=1, PCSource=01. BEQ gives BranchNE=0. Both take 3 cycles.
- Opcode 111111 → IllegalOp=1. Without macro, next state is FETCH. With ILLEGAL_OP_TRAP_EN, the FSM stays in TRAP with all enables 0 for 10 cycles, until reset.
